// File: rtl/present_pkg.sv
// PRESENT-80 constants, decryptor FSM encoding and the round/key-schedule helpers
// shared by the decryption core and its substitution-permutation block.
package present_pkg;

  localparam int ROUNDS = 31;

  localparam logic [3:0] PRESENT_SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] PRESENT_INV_SBOX [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    KEY_EXP = 2'd1,
    DECRYPT = 2'd2,
    OUTPUT  = 2'd3
  } dec_state_t;

  function automatic logic [3:0] sbox_nib(input logic [3:0] nib);
    return PRESENT_SBOX[nib];
  endfunction

  function automatic logic [3:0] inv_sbox_nib(input logic [3:0] nib);
    return PRESENT_INV_SBOX[nib];
  endfunction

  // The forward layer sends bit i to (16*i) mod 63, so undoing it pulls bit i from there.
  function automatic logic [63:0] inv_perm64(input logic [63:0] y);
    logic [63:0] x;
    x = '0;
    for (int i = 0; i < 63; i++) begin
      x[6'(i)] = y[6'((16 * i) % 63)];
    end
    x[63] = y[63];
    return x;
  endfunction

  function automatic logic [79:0] key_fwd_update(input logic [79:0] key, input logic [4:0] ctr);
    logic [79:0] k;
    k          = {key[18:0], key[79:19]};
    k[79:76]   = sbox_nib(k[79:76]);
    k[19:15]   = k[19:15] ^ ctr;
    return k;
  endfunction

  // Exact inverse of key_fwd_update for the same round counter value.
  function automatic logic [79:0] key_inv_update(input logic [79:0] key, input logic [4:0] ctr);
    logic [79:0] k;
    k          = key;
    k[19:15]   = k[19:15] ^ ctr;
    k[79:76]   = inv_sbox_nib(k[79:76]);
    return {k[60:0], k[79:61]};
  endfunction

endpackage

// File: rtl/inv_sub_per.sv
// Combinational inverse PRESENT round layer: inverse bit permutation, then the
// inverse S-box on all 16 nibbles.
module inv_sub_per
  import present_pkg::*;
(
  input  logic [63:0] data_i,
  output logic [63:0] data_o
);

  logic [63:0] perm;

  always_comb begin
    perm   = inv_perm64(data_i);
    data_o = '0;
    for (int n = 0; n < 16; n++) begin
      data_o[4*n +: 4] = inv_sbox_nib(perm[4*n +: 4]);
    end
  end

endmodule

// File: rtl/present_decryptor_top.sv
// Iterative PRESENT-80 decryption core: expands the key once to cache K32, then
// decrypts each block one round per clock while unwinding the key schedule.
module present_decryptor_top
  import present_pkg::*;
#(
  parameter int ROUNDS = present_pkg::ROUNDS
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [79:0] key_i,
  input  logic        key_valid_i,
  output logic        key_ready_o,
  input  logic [63:0] data_i,
  input  logic        data_valid_i,
  output logic        data_ready_o,
  output logic [63:0] data_o,
  output logic        data_valid_o
);

  localparam logic [4:0] LAST_CTR = 5'(ROUNDS);

  dec_state_t  fsm_q, fsm_d;
  logic        key_loaded_q, key_loaded_d;
  logic [4:0]  ctr_q, ctr_d;
  logic [63:0] data_q, data_d;
  logic        data_valid_q, data_valid_d;
  logic [63:0] blk_q, blk_d;
  logic [79:0] work_key_q, work_key_d;
  logic [79:0] k32_q, k32_d;
  logic [63:0] round_in;
  logic [63:0] round_out;

  // Round-key addition feeds both the inverse round and the final whitening.
  assign round_in = blk_q ^ work_key_q[79:16];

  inv_sub_per u_inv_sub_per (
    .data_i (round_in),
    .data_o (round_out)
  );

  always_comb begin
    fsm_d        = fsm_q;
    key_loaded_d = key_loaded_q;
    ctr_d        = ctr_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    blk_d        = blk_q;
    work_key_d   = work_key_q;
    k32_d        = k32_q;
    key_ready_o  = 1'b0;
    data_ready_o = 1'b0;

    unique case (fsm_q)
      IDLE: begin
        key_ready_o  = 1'b1;
        data_ready_o = key_loaded_q & ~key_valid_i;
        if (key_valid_i) begin
          work_key_d = key_i;
          ctr_d      = 5'd1;
          fsm_d      = KEY_EXP;
        end else if (data_valid_i && key_loaded_q) begin
          blk_d      = data_i;
          work_key_d = k32_q;
          ctr_d      = LAST_CTR;
          fsm_d      = DECRYPT;
        end
      end

      KEY_EXP: begin
        work_key_d = key_fwd_update(work_key_q, ctr_q);
        if (ctr_q == LAST_CTR) begin
          k32_d        = work_key_d;
          key_loaded_d = 1'b1;
          fsm_d        = IDLE;
        end else begin
          ctr_d = ctr_q + 5'd1;
        end
      end

      DECRYPT: begin
        blk_d      = round_out;
        work_key_d = key_inv_update(work_key_q, ctr_q);
        ctr_d      = ctr_q - 5'd1;
        if (ctr_q == 5'd1) begin
          fsm_d = OUTPUT;
        end
      end

      OUTPUT: begin
        data_d       = round_in;
        data_valid_d = 1'b1;
        fsm_d        = IDLE;
      end

      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q        <= IDLE;
      key_loaded_q <= 1'b0;
      ctr_q        <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      key_loaded_q <= key_loaded_d;
      ctr_q        <= ctr_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Round state and key registers are qualified by the FSM, so they carry no reset.
  always_ff @(posedge clk_i) begin
    blk_q      <= blk_d;
    work_key_q <= work_key_d;
    k32_q      <= k32_d;
  end

  assign data_o       = data_q;
  assign data_valid_o = data_valid_q;

endmodule
